// File: rtl/msdf_pkg.sv
// Shared encodings for the MSDF online-multiplier back end:
// signed-digit codes and the converter FSM state codes.
package msdf_pkg;

  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b01;
  localparam logic [1:0] DIG_ZERO = 2'b00;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SKIP    = 2'd1;
  localparam logic [1:0] ST_CONVERT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/otf_step.sv
// One on-the-fly conversion step: appends a signed digit to the Q/QM pair,
// keeping QM = Q - 1 so no carry chain is ever needed.
module otf_step
  import msdf_pkg::*;
#(
  parameter int W = 17
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  logic [1:0]   digit,
  output logic [W-1:0] q_next,
  output logic [W-1:0] qm_next
);

  always_comb begin
    q_next  = {q[W-2:0], 1'b0};
    qm_next = {qm[W-2:0], 1'b1};
    case (digit)
      DIG_POS: begin
        q_next  = {q[W-2:0], 1'b1};
        qm_next = {q[W-2:0], 1'b0};
      end
      // A borrow is absorbed by switching to the QM branch.
      DIG_NEG: begin
        q_next  = {qm[W-2:0], 1'b1};
        qm_next = {qm[W-2:0], 1'b0};
      end
      DIG_ZERO: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/msdf_otf_converter.sv
// Drops the online-delay digits of the product stream, then converts the
// next N signed digits to an (N+1)-bit two's-complement result.
module msdf_otf_converter
  import msdf_pkg::*;
#(
  parameter int N     = 16,
  parameter int DELTA = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         din_valid,
  input  logic [1:0]   pi,
  output logic [N:0]   result,
  output logic         done,
  output logic         busy
);

  localparam int W       = N + 1;
  localparam int CNT_MAX = (N > DELTA) ? N : DELTA;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DELTA_C = CW'(DELTA);
  localparam logic [CW-1:0] N_C     = CW'(N);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [W-1:0]  q;
  logic [W-1:0]  qm;
  logic [W-1:0]  q_next;
  logic [W-1:0]  qm_next;

  otf_step #(.W(W)) u_step (
    .q       (q),
    .qm      (qm),
    .digit   (pi),
    .q_next  (q_next),
    .qm_next (qm_next)
  );

  assign cnt_inc = cnt + CW'(1);
  assign done    = (state == ST_DONE);
  assign busy    = (state == ST_SKIP) || (state == ST_CONVERT);

  // Input stream has no back-pressure: pi is taken on every rising edge where
  // din_valid is high while busy; din_valid low is a stall that freezes all state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      q      <= '0;
      qm     <= '1;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            q     <= '0;
            qm    <= '1;
            cnt   <= '0;
            state <= (DELTA == 0) ? ST_CONVERT : ST_SKIP;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SKIP: begin
          if (din_valid) begin
            if (cnt_inc == DELTA_C) begin
              cnt   <= '0;
              state <= ST_CONVERT;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        ST_CONVERT: begin
          if (din_valid) begin
            q  <= q_next;
            qm <= qm_next;
            if (cnt_inc == N_C) begin
              cnt    <= '0;
              result <= q_next;
              state  <= ST_DONE;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msdf_otf_converter.sv
// Directed bench for msdf_otf_converter at N=4, DELTA=3 with hand-computed
// results, latencies, stall, async reset, restart and ignored-start cases.
module tb_msdf_otf_converter;

  localparam int N     = 4;
  localparam int DELTA = 3;
  localparam int RW    = N + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          din_valid;
  logic [1:0]    pi;
  logic [RW-1:0] result;
  logic          done;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  int lat;

  always #5 clk = ~clk;

  msdf_otf_converter #(.N(N), .DELTA(DELTA)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din_valid (din_valid),
    .pi        (pi),
    .result    (result),
    .done      (done),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with start already high; feeds 3 junk digits then the
  // 4 digits of digs (MSD in [7:6]); returns cycles from start edge to done.
  task automatic feed(input logic [7:0] digs, input int skip_stall, input int conv_stall,
                      input int pulse_at, input logic [RW-1:0] prev, output int cycles);
    logic [2:0] items[$];
    bit seen;
    items = {};
    seen  = 1'b0;
    for (int i = 0; i < skip_stall; i++) items.push_back(3'b010);
    items.push_back(3'b110);
    items.push_back(3'b101);
    items.push_back(3'b110);
    items.push_back({1'b1, digs[7:6]});
    items.push_back({1'b1, digs[5:4]});
    for (int i = 0; i < conv_stall; i++) items.push_back(3'b010);
    items.push_back({1'b1, digs[3:2]});
    items.push_back({1'b1, digs[1:0]});
    cycles = 0;
    while (!seen && cycles < 60) begin
      @(negedge clk);
      cycles++;
      start = (cycles == pulse_at);
      if (cycles == 1) begin
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_after_start", 32'(done), 32'd0);
        check("result_held", 32'(result), 32'(prev));
      end
      if (done) begin
        seen = 1'b1;
        din_valid = 1'b0;
        pi = 2'b00;
      end else if (items.size() > 0) begin
        {din_valid, pi} = items.pop_front();
      end else begin
        din_valid = 1'b0;
        pi = 2'b00;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    din_valid = 1'b0;
    pi = 2'b00;
    #12;
    check("reset_result", 32'(result), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // +1, 0, -1, +1 -> 8 - 2 + 1 = 7
    start = 1'b1;
    feed(8'b10_00_01_10, 0, 0, 0, 5'd0, lat);
    check("s1_latency", 32'(lat), 32'd8);
    check("s1_result", 32'(result), 32'(5'b00111));
    check("s1_busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("s1_done_one_cycle", 32'(done), 32'd0);
    check("s1_idle_busy", 32'(busy), 32'd0);

    // four -1 digits -> -15
    start = 1'b1;
    feed(8'b01_01_01_01, 0, 0, 0, 5'b00111, lat);
    check("neg_latency", 32'(lat), 32'd8);
    check("neg_result", 32'(result), 32'(5'b10001));

    // four 2'b11 (zero) digits -> 0
    @(negedge clk);
    start = 1'b1;
    feed(8'b11_11_11_11, 0, 0, 0, 5'b10001, lat);
    check("zero_result", 32'(result), 32'd0);

    // stalls: 2 in SKIP, 3 in CONVERT -> 5 extra cycles
    @(negedge clk);
    start = 1'b1;
    feed(8'b10_00_01_10, 2, 3, 0, 5'd0, lat);
    check("stall_latency", 32'(lat), 32'd13);
    check("stall_result", 32'(result), 32'(5'b00111));

    // async reset after the 2nd converted digit
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      din_valid = 1'b1;
      case (i)
        1, 3: pi = 2'b10;
        2: pi = 2'b01;
        4: pi = 2'b10;
        default: pi = 2'b00;
      endcase
    end
    @(negedge clk);
    din_valid = 1'b0;
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_result", 32'(result), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    #1 reset = 1'b0;
    @(negedge clk);
    start = 1'b1;
    feed(8'b10_00_01_10, 0, 0, 0, 5'd0, lat);
    check("post_reset_latency", 32'(lat), 32'd8);
    check("post_reset_result", 32'(result), 32'(5'b00111));

    // start held in the DONE cycle: back-to-back conversion of +1 x4 -> 15
    start = 1'b1;
    feed(8'b10_10_10_10, 0, 0, 0, 5'b00111, lat);
    check("restart_latency", 32'(lat), 32'(DELTA + N + 1));
    check("restart_result", 32'(result), 32'(5'b01111));

    // start pulsed during CONVERT is ignored
    @(negedge clk);
    start = 1'b1;
    feed(8'b10_00_01_10, 0, 0, 6, 5'b01111, lat);
    check("ignored_start_latency", 32'(lat), 32'd8);
    check("ignored_start_result", 32'(result), 32'(5'b00111));
    @(negedge clk);
    check("ignored_start_no_rerun", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
